// File: rtl/gram_access_arbiter.sv
// GRAM (ED/DD bank) arbiter between the Z80 and display fetch for MZ-80B/MZ-2000 boards.
// Sequences one CPU access in BLANK or a free display slot, holding the CPU with nWAIT.
module gram_access_arbiter #(
    parameter int unsigned ACC_CYCLES = 2,
    parameter int unsigned MAX_WAIT   = 255,
    parameter int unsigned WAIT_W     = 8,
    parameter bit          GAP_ALLOW  = 1'b1
) (
    input  logic CLK,
    input  logic nRST,
    input  logic nMREQ,
    input  logic nRD,
    input  logic nRFSH,
    input  logic sel_ed,
    input  logic sel_dd,
    input  logic BLANK,
    input  logic disp_req,
    output logic nWAIT,
    output logic nCSED,
    output logic nCSDD,
    output logic nGRD,
    output logic nGWR,
    output logic disp_gnt,
    output logic timeout_flag
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAITG  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [2:0]        ACC_LAST = 3'(ACC_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t            r_state;
    logic [2:0]        r_acc_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_tgt_dd;
    logic              r_rd;
    logic              r_ncsed;
    logic              r_ncsdd;
    logic              r_ngrd;
    logic              r_ngwr;
    logic              r_timeout;

    state_t            w_nxt_state;
    logic [2:0]        w_nxt_acc;
    logic [WAIT_W-1:0] w_nxt_wait;
    logic              w_nxt_tgt_dd;
    logic              w_nxt_rd;
    logic              w_set_to;
    logic              w_nxt_busy;
    logic              w_req;
    logic              w_grant;

    assign w_req   = ~nMREQ & nRFSH & (sel_ed | sel_dd);
    assign w_grant = BLANK | (GAP_ALLOW & ~disp_req);

    // Next-state, counter and latched-attribute logic
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_acc    = r_acc_cnt;
        w_nxt_wait   = r_wait_cnt;
        w_nxt_tgt_dd = r_tgt_dd;
        w_nxt_rd     = r_rd;
        w_set_to     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_nxt_tgt_dd = ~sel_ed;
                    w_nxt_rd     = ~nRD;
                    if (w_grant) begin
                        w_nxt_state = ST_ACCESS;
                        w_nxt_acc   = 3'd0;
                    end else begin
                        w_nxt_state = ST_WAITG;
                        w_nxt_wait  = {WAIT_W{1'b0}};
                    end
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_WAITG: begin
                if (!w_req) begin
                    w_nxt_state = ST_IDLE;
                end else if (w_grant) begin
                    w_nxt_state = ST_ACCESS;
                    w_nxt_acc   = 3'd0;
                end else if (r_wait_cnt == WAIT_MAX) begin
                    // Display starved the CPU too long: force the grant and remember it
                    w_nxt_state = ST_ACCESS;
                    w_nxt_acc   = 3'd0;
                    w_set_to    = 1'b1;
                end else begin
                    w_nxt_wait  = r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_ACCESS: begin
                if (!w_req) begin
                    w_nxt_state = ST_IDLE;
                end else if (r_acc_cnt == ACC_LAST) begin
                    w_nxt_state = ST_DONE;
                end else begin
                    w_nxt_acc   = r_acc_cnt + 3'd1;
                end
            end
            ST_DONE: begin
                if (nMREQ) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_state = ST_DONE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    assign w_nxt_busy = (w_nxt_state == ST_ACCESS) | (w_nxt_state == ST_DONE);

    // State, counters, latched target/direction and the registered selects/strobes
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= ST_IDLE;
            r_acc_cnt  <= 3'd0;
            r_wait_cnt <= {WAIT_W{1'b0}};
            r_tgt_dd   <= 1'b0;
            r_rd       <= 1'b1;
            r_ncsed    <= 1'b1;
            r_ncsdd    <= 1'b1;
            r_ngrd     <= 1'b1;
            r_ngwr     <= 1'b1;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_acc_cnt  <= w_nxt_acc;
            r_wait_cnt <= w_nxt_wait;
            r_tgt_dd   <= w_nxt_tgt_dd;
            r_rd       <= w_nxt_rd;
            r_ncsed    <= ~(w_nxt_busy & ~w_nxt_tgt_dd);
            r_ncsdd    <= ~(w_nxt_busy & w_nxt_tgt_dd);
            r_ngrd     <= ~(w_nxt_busy & w_nxt_rd);
            // Write strobe releases on entering DONE so data is held past the strobe edge
            r_ngwr     <= ~((w_nxt_state == ST_ACCESS) & ~w_nxt_rd);
            r_timeout  <= r_timeout | w_set_to;
        end
    end

    assign nWAIT = ~(w_req & ((r_state == ST_IDLE) | (r_state == ST_WAITG) |
                              ((r_state == ST_ACCESS) & (r_acc_cnt != ACC_LAST))));
    assign disp_gnt     = ~BLANK & ~((r_state == ST_ACCESS) | (r_state == ST_DONE));
    assign nCSED        = r_ncsed;
    assign nCSDD        = r_ncsdd;
    assign nGRD         = r_ngrd;
    assign nGWR         = r_ngwr;
    assign timeout_flag = r_timeout;

endmodule

// File: tb/tb_gram_access_arbiter.sv
// Directed self-checking bench for gram_access_arbiter (GAP_ALLOW=1 and GAP_ALLOW=0 instances).
module tb_gram_access_arbiter;

    logic CLK = 1'b0;
    logic nRST, nMREQ, nRD, nRFSH, sel_ed, sel_dd, BLANK, disp_req;
    logic a_nwait, a_ncsed, a_ncsdd, a_ngrd, a_ngwr, a_dgnt, a_to;
    logic b_nwait, b_ncsed, b_ncsdd, b_ngrd, b_ngwr, b_dgnt, b_to;
    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    gram_access_arbiter #(.ACC_CYCLES(2), .MAX_WAIT(255), .WAIT_W(8), .GAP_ALLOW(1'b1)) u_a (
        .CLK(CLK), .nRST(nRST), .nMREQ(nMREQ), .nRD(nRD), .nRFSH(nRFSH),
        .sel_ed(sel_ed), .sel_dd(sel_dd), .BLANK(BLANK), .disp_req(disp_req),
        .nWAIT(a_nwait), .nCSED(a_ncsed), .nCSDD(a_ncsdd), .nGRD(a_ngrd), .nGWR(a_ngwr),
        .disp_gnt(a_dgnt), .timeout_flag(a_to));

    gram_access_arbiter #(.ACC_CYCLES(2), .MAX_WAIT(255), .WAIT_W(8), .GAP_ALLOW(1'b0)) u_b (
        .CLK(CLK), .nRST(nRST), .nMREQ(nMREQ), .nRD(nRD), .nRFSH(nRFSH),
        .sel_ed(sel_ed), .sel_dd(sel_dd), .BLANK(BLANK), .disp_req(disp_req),
        .nWAIT(b_nwait), .nCSED(b_ncsed), .nCSDD(b_ncsdd), .nGRD(b_ngrd), .nGWR(b_ngwr),
        .disp_gnt(b_dgnt), .timeout_flag(b_to));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Bring the bus back to idle and let both instances return to IDLE
    task automatic bus_idle();
        nMREQ = 1'b1; nRD = 1'b1; nRFSH = 1'b1; sel_ed = 1'b0; sel_dd = 1'b0;
        step();
        step();
    endtask

    initial begin
        nRST = 1'b0; nMREQ = 1'b0; nRD = 1'b0; nRFSH = 1'b1;
        sel_ed = 1'b1; sel_dd = 1'b0; BLANK = 1'b1; disp_req = 1'b0;

        // Reset held with a live request
        step(); step();
        chk("rst_csed", a_ncsed, 1); chk("rst_csdd", a_ncsdd, 1);
        chk("rst_grd", a_ngrd, 1);   chk("rst_gwr", a_ngwr, 1);
        chk("rst_to", a_to, 0);      chk("rst_dgnt", a_dgnt, 0);
        nMREQ = 1'b1; sel_ed = 1'b0; nRD = 1'b1;
        #2 nRST = 1'b1;
        step();
        chk("rst_nwait", a_nwait, 1);

        // Blank read of ED
        BLANK = 1'b1; sel_ed = 1'b1; nRD = 1'b0; nMREQ = 1'b0;
        #1 chk("rd_idle_wait", a_nwait, 0); chk("rd_idle_cs", a_ncsed, 1);
        step();
        chk("rd_a0_wait", a_nwait, 0); chk("rd_a0_cs", a_ncsed, 0); chk("rd_a0_grd", a_ngrd, 0);
        chk("rd_a0_csdd", a_ncsdd, 1); chk("rd_a0_gwr", a_ngwr, 1);
        step();
        chk("rd_a1_wait", a_nwait, 1); chk("rd_a1_cs", a_ncsed, 0); chk("rd_a1_grd", a_ngrd, 0);
        step();
        chk("rd_done_cs", a_ncsed, 0); chk("rd_done_grd", a_ngrd, 0); chk("rd_done_wait", a_nwait, 1);
        step();
        chk("rd_hold_cs", a_ncsed, 0); chk("rd_hold_csdd", a_ncsdd, 1);
        nMREQ = 1'b1;
        step();
        chk("rd_end_cs", a_ncsed, 1); chk("rd_end_grd", a_ngrd, 1);
        bus_idle();

        // Active-display write of DD
        BLANK = 1'b0; disp_req = 1'b1; sel_dd = 1'b1; nRD = 1'b1; nMREQ = 1'b0;
        #1 chk("wr_idle_dgnt", a_dgnt, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wr_wg_wait", a_nwait, 0); chk("wr_wg_dgnt", a_dgnt, 1);
            chk("wr_wg_cs", a_ncsdd, 1);   chk("wr_wg_gwr", a_ngwr, 1);
        end
        disp_req = 1'b0;
        step();
        disp_req = 1'b1;
        #1;
        chk("wr_a0_cs", a_ncsdd, 0); chk("wr_a0_gwr", a_ngwr, 0); chk("wr_a0_grd", a_ngrd, 1);
        chk("wr_a0_csed", a_ncsed, 1); chk("wr_a0_dgnt", a_dgnt, 0); chk("wr_a0_wait", a_nwait, 0);
        chk("wr_b_stay", b_ncsdd, 1);
        step();
        chk("wr_a1_gwr", a_ngwr, 0); chk("wr_a1_wait", a_nwait, 1);
        step();
        chk("wr_done_gwr", a_ngwr, 1); chk("wr_done_cs", a_ncsdd, 0); chk("wr_done_dgnt", a_dgnt, 0);
        nMREQ = 1'b1;
        step();
        chk("wr_end_cs", a_ncsdd, 1); chk("wr_end_dgnt", a_dgnt, 1); chk("wr_end_to", a_to, 0);
        bus_idle();

        // Timeout: display never yields
        BLANK = 1'b0; disp_req = 1'b1; sel_ed = 1'b1; nRD = 1'b0; nMREQ = 1'b0;
        step();
        for (int i = 0; i < 255; i++) step();
        chk("to_255_cs", a_ncsed, 1); chk("to_255_flag", a_to, 0); chk("to_255_wait", a_nwait, 0);
        step();
        chk("to_acc_cs", a_ncsed, 0); chk("to_acc_grd", a_ngrd, 0); chk("to_flag", a_to, 1);
        step(); step();
        nMREQ = 1'b1;
        step(); step(); step();
        chk("to_sticky", a_to, 1); chk("to_idle_cs", a_ncsed, 1);
        bus_idle();

        // Abort from WAITG
        BLANK = 1'b0; disp_req = 1'b1; sel_ed = 1'b1; nRD = 1'b0; nMREQ = 1'b0;
        step(); step();
        nMREQ = 1'b1;
        #1 chk("ab_wait", a_nwait, 1);
        BLANK = 1'b1;
        step();
        chk("ab_cs", a_ncsed, 1);
        step();
        chk("ab_cs2", a_ncsed, 1); chk("ab_grd", a_ngrd, 1);
        bus_idle();

        // ED wins when both banks hit
        BLANK = 1'b1; disp_req = 1'b0; sel_ed = 1'b1; sel_dd = 1'b1; nRD = 1'b0; nMREQ = 1'b0;
        step();
        chk("pri_csed", a_ncsed, 0); chk("pri_csdd", a_ncsdd, 1);
        step(); step();
        chk("pri_done_csdd", a_ncsdd, 1);
        bus_idle();

        // Refresh never requests
        nRFSH = 1'b0; sel_ed = 1'b1; nMREQ = 1'b0; BLANK = 1'b1;
        #1 chk("rfsh_wait", a_nwait, 1);
        step();
        chk("rfsh_cs", a_ncsed, 1);
        bus_idle();

        // Reset mid-access drops selects without a clock
        BLANK = 1'b1; sel_ed = 1'b1; nRD = 1'b0; nMREQ = 1'b0;
        step();
        chk("mr_cs_on", a_ncsed, 0);
        #2 nRST = 1'b0;
        #1 chk("mr_cs", a_ncsed, 1); chk("mr_grd", a_ngrd, 1); chk("mr_to", a_to, 0);
        nMREQ = 1'b1; sel_ed = 1'b0; nRD = 1'b1;
        #1 nRST = 1'b1;
        bus_idle();

        // GAP_ALLOW=0 instance waits for BLANK even in an idle display slot
        BLANK = 1'b0; disp_req = 1'b0; sel_dd = 1'b1; nRD = 1'b1; nMREQ = 1'b0;
        step();
        chk("gap_a_cs", a_ncsdd, 0); chk("gap_b_cs", b_ncsdd, 1);
        step(); step();
        chk("gap_b_cs2", b_ncsdd, 1); chk("gap_b_wait", b_nwait, 0); chk("gap_b_dgnt", b_dgnt, 1);
        BLANK = 1'b1;
        step();
        chk("gap_b_acc_cs", b_ncsdd, 0); chk("gap_b_acc_gwr", b_ngwr, 0);
        bus_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
